// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array job scheduler: FSM state encoding
// and a width helper used for index and counter sizing.
package sa_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_LOAD,
        ST_WAIT_CAL,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Bits needed to hold values 0..value-1, never less than one bit.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) width++;
        return width;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last winner and wraps,
// so every continuously requesting input is served within NREQ grants.
module rr_arbiter
    import sa_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]        req,
    input  logic [clog2(NREQ)-1:0] last,
    output logic [NREQ-1:0]        grant,
    output logic [clog2(NREQ)-1:0] idx
);

    localparam int IW = clog2(NREQ);

    logic [IW-1:0] cand;

    // Scan from the farthest offset down so the nearest requester wins.
    always_comb begin
        idx   = '0;
        grant = '0;
        cand  = '0;
        for (int i = NREQ; i >= 1; i--) begin
            cand = IW'((int'(last) + i) % NREQ);
            if (req[cand]) idx = cand;
        end
        grant[idx] = |req;
    end

endmodule

// File: rtl/sa_scheduler.sv
// Job scheduler for a systolic array: arbitrates requesters, opens the operand
// load windows, waits for the calculation and drain, then reports done or timeout.
module sa_scheduler
    import sa_pkg::*;
#(
    parameter int X       = 3,
    parameter int N       = 3,
    parameter int Y       = 3,
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   sys_rst_n,
    input  logic [NREQ-1:0]        req,
    output logic [NREQ-1:0]        ack,
    output logic [NREQ-1:0]        done,
    output logic                   err,
    output logic [clog2(NREQ)-1:0] grant_id,
    output logic                   busy,
    output logic                   Xin_val,
    output logic                   Yin_val,
    input  logic                   cal_done,
    input  logic                   out_last_rd_en
);

    localparam int IW   = clog2(NREQ);
    localparam int XN   = X * N;
    localparam int NY   = N * Y;
    localparam int MAXL = (XN > NY) ? XN : NY;
    localparam int LW   = clog2(MAXL + 1);
    localparam int TW   = clog2(TIMEOUT + 1);

    localparam logic [LW-1:0] XN_C      = LW'(XN);
    localparam logic [LW-1:0] NY_C      = LW'(NY);
    localparam logic [LW-1:0] MAXL_C    = LW'(MAXL);
    localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT);

    state_t          state_q, state_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;
    logic            xin_val_q, xin_val_d;
    logic            yin_val_q, yin_val_d;
    logic [IW-1:0]   grant_id_q, grant_id_d;
    logic [IW-1:0]   last_q, last_d;
    logic [LW-1:0]   load_cnt_q, load_cnt_d;
    logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic            rd_en_q, rd_en_d;

    logic [NREQ-1:0] arb_grant;
    logic [IW-1:0]   arb_idx;
    logic [TW-1:0]   tmo_next;
    logic            rd_fall;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (req),
        .last  (last_q),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    always_comb begin
        state_d    = state_q;
        ack_d      = '0;
        done_d     = '0;
        err_d      = 1'b0;
        xin_val_d  = 1'b0;
        yin_val_d  = 1'b0;
        grant_id_d = grant_id_q;
        last_d     = last_q;
        load_cnt_d = load_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        rd_en_d    = out_last_rd_en;
        tmo_next   = tmo_cnt_q + 1'b1;
        rd_fall    = rd_en_q & ~out_last_rd_en;

        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d    = ST_GRANT;
                    ack_d      = arb_grant;
                    grant_id_d = arb_idx;
                end
            end
            ST_GRANT: begin
                state_d    = ST_LOAD;
                xin_val_d  = 1'b1;
                yin_val_d  = 1'b1;
                load_cnt_d = LW'(1);
            end
            // load_cnt_q counts window cycles already presented, including this one.
            ST_LOAD: begin
                xin_val_d  = (load_cnt_q < XN_C);
                yin_val_d  = (load_cnt_q < NY_C);
                load_cnt_d = load_cnt_q + 1'b1;
                if (load_cnt_q == MAXL_C) begin
                    state_d    = ST_WAIT_CAL;
                    load_cnt_d = '0;
                    tmo_cnt_d  = '0;
                end
            end
            ST_WAIT_CAL, ST_DRAIN: begin
                tmo_cnt_d = tmo_next;
                if (tmo_next == TIMEOUT_C) begin
                    state_d   = ST_IDLE;
                    err_d     = 1'b1;
                    last_d    = grant_id_q;
                    tmo_cnt_d = '0;
                end else if (state_q == ST_WAIT_CAL && cal_done) begin
                    state_d = ST_DRAIN;
                end else if (state_q == ST_DRAIN && rd_fall) begin
                    state_d            = ST_DONE;
                    done_d[grant_id_q] = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                last_d  = grant_id_q;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_IDLE;
            ack_q      <= '0;
            done_q     <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            xin_val_q  <= 1'b0;
            yin_val_q  <= 1'b0;
            grant_id_q <= '0;
            last_q     <= IW'(NREQ - 1);
            load_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            rd_en_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            done_q     <= done_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            xin_val_q  <= xin_val_d;
            yin_val_q  <= yin_val_d;
            grant_id_q <= grant_id_d;
            last_q     <= last_d;
            load_cnt_q <= load_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            rd_en_q    <= rd_en_d;
        end
    end

    assign ack      = ack_q;
    assign done     = done_q;
    assign err      = err_q;
    assign busy     = busy_q;
    assign Xin_val  = xin_val_q;
    assign Yin_val  = yin_val_q;
    assign grant_id = grant_id_q;

endmodule

// File: doc/sa_scheduler.md
SA_SCHEDULER -- requirements
Module: sa_scheduler

Interface
REQ-001 Param X, 3: systolic array rows.
REQ-002 Param N, 3: inner (shared) dimension.
REQ-003 Param Y, 3: array columns.
REQ-004 Param NREQ, 2: number of requesters, 2..8.
REQ-005 Param TIMEOUT, 255: max cycles in WAIT_CAL plus DRAIN.
REQ-006 Port clk, in, 1: single clock; all logic rising-edge.
REQ-007 Port sys_rst_n, in, 1: asynchronous active-low reset.
REQ-008 Port req, in, NREQ: per-requester job request, level, held until ack.
REQ-009 Port ack, out, NREQ: one-hot one-cycle grant pulse.
REQ-010 Port done, out, NREQ: one-hot one-cycle job-complete pulse to granted requester.
REQ-011 Port err, out, 1: one-cycle timeout pulse.
REQ-012 Port grant_id, out, clog2(NREQ) (min 1): index of owner, selects operand/result muxes; stable from ack until done/err.
REQ-013 Port busy, out, 1: high in every state except IDLE.
REQ-014 Port Xin_val, out, 1: west operand write window to array config.
REQ-015 Port Yin_val, out, 1: north operand write window to array config.
REQ-016 Port cal_done, in, 1: one-cycle end-of-calculation pulse from array config.
REQ-017 Port out_last_rd_en, in, 1: last-row output FIFO read enable from array config.

Function
REQ-018 FSM states SHALL be IDLE, GRANT, LOAD, WAIT_CAL, DRAIN, DONE.
REQ-019 IDLE: if any req bit set, pick winner by round-robin starting at (last winner+1) mod NREQ; go GRANT.
REQ-020 GRANT (1 cycle): ack[winner]=1, grant_id=winner; go LOAD.
REQ-021 LOAD: Xin_val high for exactly X*N consecutive cycles, Yin_val high for exactly N*Y consecutive cycles, both rising in the first LOAD cycle; leave LOAD when both windows complete.
REQ-022 Xin_val and Yin_val SHALL be registered outputs; each SHALL be low for at least one cycle between jobs so array config sees a fresh rising edge.
REQ-023 WAIT_CAL: on cal_done go DRAIN; cal_done in any other state is ignored.
REQ-024 DRAIN: on falling edge of out_last_rd_en (registered compare) go DONE.
REQ-025 DONE (1 cycle): done[grant_id]=1; update last winner; go IDLE.
REQ-026 Timeout counter (width clog2(TIMEOUT+1)) clears on entering WAIT_CAL, increments in WAIT_CAL/DRAIN; at TIMEOUT pulse err, no done, go IDLE, last winner still updated.
REQ-027 cal_done and out_last_rd_en falling edge in same cycle while WAIT_CAL: take WAIT_CAL->DRAIN only; falling edge is missed and timeout recovers.
REQ-028 req changes outside IDLE SHALL be ignored; newly raised req waits for next IDLE arbitration.
REQ-029 Round-robin SHALL guarantee each continuously asserting requester is granted within NREQ jobs.
REQ-030 Back-to-back: IDLE after DONE is one cycle minimum; pending req granted on next cycle.

Reset
REQ-031 On sys_rst_n low, asynchronously: state=IDLE, ack=0, done=0, err=0, busy=0, Xin_val=0, Yin_val=0, grant_id=0, last winner=NREQ-1, counters=0.
REQ-032 Reset mid-job abandons the job with no done/err pulse; array config is reset by the same sys_rst_n.

Structure
REQ-033 State encoding and a clog2 helper function SHALL live in shared package sa_pkg.
REQ-034 Round-robin arbiter SHALL be sub-module rr_arbiter (req, last-winner in; one-hot grant, index out).
REQ-035 All outputs SHALL be registered; no combinational path from input to output.

Verification (X=N=Y=3, NREQ=2, TIMEOUT=255)
REQ-036 req=01 once -> ack=01 at T+1, Xin_val and Yin_val each high exactly 9 cycles, done=01 one cycle after out_last_rd_en falls.
REQ-037 req=11 held -> grants alternate 0,1,0,1; grant_id matches each ack; no starvation over 4 jobs.
REQ-038 cal_done withheld -> err pulse exactly 255 cycles after entering WAIT_CAL, no done, busy=0 next cycle.
REQ-039 cal_done pulsed during LOAD -> ignored; FSM stays LOAD, completes normally on a later cal_done.
REQ-040 sys_rst_n low during LOAD cycle 5 -> all outputs 0 immediately; after release req=10 granted to requester 1 first (last winner=1 resets to NREQ-1, so requester 0 wins if both asserted).
REQ-041 Two jobs back-to-back -> Xin_val low at least one cycle between windows; second job's window matches first.
